// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII stream blocks (transmitter and pattern detectors).
package ascii_pkg;

    localparam int unsigned CHAR_W = 8;

    localparam logic [CHAR_W-1:0] ASCII_NUL = 8'h00;
    localparam logic [CHAR_W-1:0] ASCII_B   = 8'h42;
    localparam logic [CHAR_W-1:0] ASCII_O   = 8'h4F;
    localparam logic [CHAR_W-1:0] ASCII_M   = 8'h4D;
    localparam logic [CHAR_W-1:0] ASCII_A   = 8'h41;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StDone = 2'd2
    } tx_state_t;

    function automatic int unsigned clamp_len(int unsigned len, int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/ascii_msg_tx_if.sv
// Host-side control and consumer-side stream handshake of the ASCII message transmitter.
interface ascii_msg_tx_if #(
    parameter int unsigned ADDR_W = 4
);
    import ascii_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CHAR_W-1:0] wr_data;
    logic [ADDR_W:0]   len;
    logic              start;
    logic              repeat_en;
    logic              abort;
    logic              ready;
    logic [CHAR_W-1:0] ascii;
    logic              valid;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, len, start, repeat_en, abort, ready,
        input  ascii, valid, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, start, repeat_en, abort, ready,
        output ascii, valid, busy, done
    );

endinterface

// File: rtl/msg_buffer.sv
// DEPTH x 8 message register file: one write port, combinational read port.
module msg_buffer
    import ascii_pkg::*;
#(
    parameter int unsigned       DEPTH     = 16,
    parameter int unsigned       ADDR_W    = 4,
    parameter logic [CHAR_W-1:0] IDLE_CHAR = ASCII_NUL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= IDLE_CHAR;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ascii_msg_tx.sv
// Plays a buffered ASCII message out over a valid/ready stream, once or looping until abort.
module ascii_msg_tx
    import ascii_pkg::*;
#(
    parameter int unsigned       DEPTH     = 16,
    parameter int unsigned       ADDR_W    = 4,
    parameter logic [CHAR_W-1:0] IDLE_CHAR = ASCII_NUL
) (
    input logic           clk,
    input logic           rst,
    ascii_msg_tx_if.slave bus
);

    localparam int unsigned LenW = ADDR_W + 1;

    tx_state_t         state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [LenW-1:0]   len_q;
    logic              rep_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic [CHAR_W-1:0] rd_data;
    logic [LenW-1:0]   len_clamped;
    logic              xfer;
    logic              last;

    // Writes only land while idle so a message in flight can never change under the consumer.
    msg_buffer #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .IDLE_CHAR (IDLE_CHAR)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en & ~busy_q),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    assign len_clamped = LenW'(clamp_len(32'(bus.len), DEPTH));
    assign xfer        = valid_q & bus.ready;
    assign last        = ({1'b0, idx_q} == (len_q - LenW'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            rep_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (len_clamped != '0) begin
                            len_q   <= len_clamped;
                            rep_q   <= bus.repeat_en;
                            idx_q   <= '0;
                            valid_q <= 1'b1;
                            state_q <= StSend;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StSend: begin
                    // Abort wins over completion: a coincident last transfer ends without done.
                    if (bus.abort) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (xfer) begin
                        if (!last) begin
                            idx_q <= idx_q + 1'b1;
                        end else if (rep_q) begin
                            idx_q <= '0;
                        end else begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.valid = valid_q;
    assign bus.ascii = valid_q ? rd_data : IDLE_CHAR;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
